// File: rtl/arbitro_registrador_8bits.sv
// Round-robin arbiter that owns a shared 8-bit register: grants one requester,
// loads its byte, and completes a four-phase req/ack handshake.
//
// state   | meaning
// IDLE    | no owner; arbitrate pending requests starting after ptr
// LOAD    | owner granted; its byte is written to Q at the end of this cycle
// RELEASE | load done, ack high; wait for the owner to drop its request
module arbitro_registrador_8bits #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int OW    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] D,
    output logic [N_REQ-1:0]       gnt,
    output logic                   ack,
    output logic [OW-1:0]          owner,
    output logic                   busy,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH-1:0]       Qn
);

    typedef enum logic [1:0] {IDLE, LOAD, RELEASE} state_t;

    state_t            state;
    logic [OW-1:0]     ptr;
    logic [OW-1:0]     win;
    logic [OW-1:0]     cand;
    logic              win_vld;
    logic [WIDTH-1:0]  d_arr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            d_arr[i] = D[i*WIDTH +: WIDTH];
        end
    end

    // Search ptr+1, ptr+2, ... so the last winner has lowest priority.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = OW'((int'(ptr) + k) % N_REQ);
            if (!win_vld && req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            ptr   <= OW'(N_REQ - 1);
            owner <= '0;
            gnt   <= '0;
            ack   <= 1'b0;
            busy  <= 1'b0;
            Q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner <= win;
                        gnt   <= N_REQ'(1) << win;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    Q     <= d_arr[owner];
                    ack   <= 1'b1;
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!req[owner]) begin
                        gnt   <= '0;
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                        ptr   <= owner;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Qn = ~Q;

endmodule

// File: tb/tb_arbitro_registrador_8bits.sv
// Bench for arbitro_registrador_8bits: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_arbitro_registrador_8bits;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  req;
    logic [31:0] D;
    logic [3:0]  gnt;
    logic        ack;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  Q;
    logic [7:0]  Qn;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: whether a transaction is open, who owns it,
    // cycles since the grant, last winner and register contents
    bit         m_active;
    logic [1:0] m_owner;
    int         m_age;
    logic [1:0] m_ptr;
    logic [7:0] m_q;

    arbitro_registrador_8bits #(.N_REQ(4), .WIDTH(8)) dut (
        .clk(clk), .clr(clr), .req(req), .D(D), .gnt(gnt), .ack(ack),
        .owner(owner), .busy(busy), .Q(Q), .Qn(Qn)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 1'b0;
        m_owner  = 2'd0;
        m_age    = 0;
        m_ptr    = 2'd3;
        m_q      = 8'h00;
    endtask

    // drive inputs for one cycle, advance the model across the edge, sample #1 after it
    task automatic cycle(input logic [3:0] r, input logic [31:0] d);
        int  idx;
        bit  found;
        req = r;
        D   = d;
        if (!m_active) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                idx = (int'(m_ptr) + k) % 4;
                if (!found && r[idx]) begin
                    found    = 1'b1;
                    m_active = 1'b1;
                    m_owner  = 2'(idx);
                    m_age    = 0;
                end
            end
        end else if (m_age == 0) begin
            m_q   = d[int'(m_owner)*8 +: 8];
            m_age = 1;
        end else if (!r[m_owner]) begin
            m_active = 1'b0;
            m_ptr    = m_owner;
        end else begin
            m_age = m_age + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        req = 4'b1111;
        D   = 32'h44332211;
        model_reset();
        #2;
        n_chk++; if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want 00", Q); end
        n_chk++; if (Qn !== 8'hFF) begin n_fail++; $display("FAIL reset_qn: got %h want FF", Qn); end
        n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
        @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_held_busy: got %b want 0", busy); end
        clr = 1'b1;
        cycle(4'b1111, 32'h44332211);
        n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
        cycle(4'b1111, 32'h44332211);
        n_chk++; if (Q !== 8'h11) begin n_fail++; $display("FAIL reset_first_q: got %h want 11", Q); end
        cycle(4'b0000, 32'h44332211);
    endtask

    task automatic test_single();
        cycle(4'b0010, 32'h0000A500);
        n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single_gnt: got %b want 0010", gnt); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_load: got %b want 0", ack); end
        cycle(4'b0010, 32'h0000A500);
        n_chk++; if (Q !== 8'hA5) begin n_fail++; $display("FAIL single_q: got %h want A5", Q); end
        n_chk++; if (Qn !== 8'h5A) begin n_fail++; $display("FAIL single_qn: got %h want 5A", Qn); end
        n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b want 1", ack); end
        cycle(4'b0010, 32'h0000A500);
        n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_hold: got %b want 1", ack); end
        cycle(4'b0000, 32'h0000A500);
        n_chk++; if ({gnt, ack, busy} !== 6'b0) begin n_fail++; $display("FAIL single_release: got gnt=%b ack=%b busy=%b want all 0", gnt, ack, busy); end
        n_chk++; if (owner !== 2'd1) begin n_fail++; $display("FAIL single_owner_hold: got %0d want 1", owner); end
    endtask

    task automatic test_fairness();
        logic [31:0] d;
        logic [1:0]  exp_o;
        d   = 32'h13121110;
        clr = 1'b0;
        #2;
        clr = 1'b1;
        model_reset();
        for (int t = 0; t < 5; t++) begin
            exp_o = 2'(t % 4);
            cycle(4'b1111, d);
            n_chk++; if (gnt !== (4'b0001 << exp_o)) begin n_fail++; $display("FAIL fair_gnt%0d: got %b want %b", t, gnt, 4'b0001 << exp_o); end
            cycle(4'b1111, d);
            n_chk++; if (Q !== 8'h10 + 8'(exp_o)) begin n_fail++; $display("FAIL fair_q%0d: got %h want %h", t, Q, 8'h10 + 8'(exp_o)); end
            cycle(4'b1111 & ~(4'b0001 << exp_o), d);
        end
    endtask

    task automatic test_ptr_skip();
        logic [31:0] d;
        d = 32'hD3C2B1A0;
        cycle(4'b0010, d);
        cycle(4'b0010, d);
        cycle(4'b0000, d);
        cycle(4'b1001, d);
        n_chk++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL skip_gnt: got %b want 1000", gnt); end
        n_chk++; if (owner !== 2'd3) begin n_fail++; $display("FAIL skip_owner: got %0d want 3", owner); end
        cycle(4'b1001, d);
        n_chk++; if (Q !== 8'hD3) begin n_fail++; $display("FAIL skip_q: got %h want D3", Q); end
        cycle(4'b0001, d);
        cycle(4'b0001, d);
        n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL skip_next_gnt: got %b want 0001", gnt); end
        cycle(4'b0001, d);
        cycle(4'b0000, d);
    endtask

    task automatic test_early_drop();
        logic [31:0] d;
        d = 32'h00F00000;
        cycle(4'b0100, d);
        n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL early_gnt: got %b want 0100", gnt); end
        cycle(4'b0000, d);
        n_chk++; if (Q !== 8'hF0) begin n_fail++; $display("FAIL early_q: got %h want F0", Q); end
        n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL early_ack: got %b want 1", ack); end
        cycle(4'b0000, d);
        n_chk++; if ({ack, busy, gnt} !== 6'b0) begin n_fail++; $display("FAIL early_idle: got ack=%b busy=%b gnt=%b want all 0", ack, busy, gnt); end
    endtask

    task automatic test_reset_mid_load();
        cycle(4'b0010, 32'h00003C00);
        cycle(4'b0010, 32'h00003C00);
        cycle(4'b0000, 32'h00003C00);
        n_chk++; if (Q !== 8'h3C) begin n_fail++; $display("FAIL midload_pre_q: got %h want 3C", Q); end
        cycle(4'b0001, 32'h000000C3);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midload_busy: got %b want 1", busy); end
        #2;
        clr = 1'b0;
        #1;
        n_chk++; if (Q !== 8'h00) begin n_fail++; $display("FAIL midload_q: got %h want 00", Q); end
        n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL midload_gnt: got %b want 0000", gnt); end
        @(posedge clk);
        #1;
        req = 4'b0000;
        clr = 1'b1;
        model_reset();
        cycle(4'b0000, 32'h000000C3);
        n_chk++; if (Q !== 8'h00) begin n_fail++; $display("FAIL midload_after_q: got %h want 00", Q); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midload_after_busy: got %b want 0", busy); end
    endtask

    // release edge coincides with new requests rising; the next grant uses the updated ptr
    task automatic test_back_to_back();
        logic [31:0] d;
        d = 32'h99887766;
        cycle(4'b0001, d);
        cycle(4'b0001, d);
        cycle(4'b1110, d);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
        cycle(4'b1110, d);
        n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL b2b_gnt: got %b want 0010", gnt); end
        cycle(4'b1110, d);
        cycle(4'b0000, d);
    endtask

    task automatic test_random();
        logic [3:0]  r;
        logic [31:0] d;
        logic [3:0]  eg;
        r = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
            d = $urandom;
            cycle(r, d);
            eg = m_active ? (4'b0001 << m_owner) : 4'b0000;
            n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, eg); end
            n_chk++; if (ack !== (m_active && m_age >= 1)) begin n_fail++; $display("FAIL rnd_ack c%0d: got %b want %b", c, ack, m_active && m_age >= 1); end
            n_chk++; if (busy !== m_active) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_active); end
            n_chk++; if (owner !== m_owner) begin n_fail++; $display("FAIL rnd_owner c%0d: got %0d want %0d", c, owner, m_owner); end
            n_chk++; if (Q !== m_q) begin n_fail++; $display("FAIL rnd_q c%0d: got %h want %h", c, Q, m_q); end
            n_chk++; if (Qn !== ~m_q) begin n_fail++; $display("FAIL rnd_qn c%0d: got %h want %h", c, Qn, ~m_q); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_ptr_skip();
        test_early_drop();
        test_reset_mid_load();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/arbitro_registrador_8bits.md
# arbitro_registrador_8bits

Round-robin arbiter and load sequencer that shares a single 8-bit storage register among up to `N_REQ` requesters. Each requester presents a data byte and raises a request. The block grants one requester at a time, loads that requester's byte into the shared register, and completes a four-phase req/ack handshake. It sits between the requesting units and the register datapath and owns all writes to that register.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `WIDTH`, default 8: register width; fixed at 8 for this block.
- `OW`, derived as `$clog2(N_REQ)`: owner index width; not user-set.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `clr` input, 1 bit: asynchronous active-low reset; `clr=0` forces the reset state immediately, independent of `clk`.
- `req` input, `N_REQ` bits: request per requester; held high until `ack` is seen.
- `D` input, `N_REQ*WIDTH` bits: packed data; requester i occupies `D[i*WIDTH +: WIDTH]`.
- `gnt` output, `N_REQ` bits: one-hot grant; all zero when no requester owns the register.
- `ack` output, 1 bit: load-complete acknowledge to the current owner.
- `owner` output, `OW` bits: index of the current or most recent winner.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.
- `Q` output, `WIDTH` bits: shared register contents.
- `Qn` output, `WIDTH` bits: always equal to `~Q`.

## Operation
- Internal state:
  - `ptr`: index of the last winner.
  - FSM with three states: IDLE, LOAD, RELEASE.
- Reset values (`clr=0`):
  - state=IDLE, `Q=8'h00`, `Qn=8'hFF`, `gnt=0`, `ack=0`, `busy=0`, `owner=0`, `ptr=N_REQ-1`.
  - Because `ptr` resets to `N_REQ-1`, requester 0 has first priority after reset.
- IDLE:
  - If `req==0`, stay in IDLE.
  - Otherwise pick the winner: the first i with `req[i]=1`, searching `ptr+1, ptr+2, …` modulo `N_REQ`.
  - Latch the winner into `owner`, set `gnt[owner]=1`, go to LOAD.
- LOAD (exactly 1 cycle):
  - `Q <= D[owner]` at the end of the cycle; `gnt` stays asserted.
  - Go to RELEASE unconditionally.
- RELEASE:
  - `gnt` and `ack` are both high.
  - On the first edge where `req[owner]=0`: clear `gnt` and `ack`, set `ptr <= owner`, go to IDLE.
- `Q` changes only at the end of LOAD or on reset. `D` of non-owners is never sampled.
- Requests from other requesters during LOAD/RELEASE are ignored; they are arbitrated in the next IDLE.
- `owner` holds its value in IDLE until the next grant.

## Timing
- `gnt`, `ack`, `busy` and `owner` are registered outputs, decoded from state/owner flops.
- `Qn` is combinational from `Q`.
- Transaction cycle by cycle, with `req[i]` first high at edge k:
  - Edge k: enter LOAD; `gnt[i]` and `busy` high after edge k.
  - Edge k+1: `Q` takes the new value; enter RELEASE; `ack` high after edge k+1.
  - Edge m (m ≥ k+2, first edge with `req[i]=0`): enter IDLE; `gnt`, `ack` and `busy` low after edge m.
  - Edge m+1: earliest next grant (IDLE lasts at least one cycle).
- The minimum transaction is 3 cycles.
- Early-drop boundary: if `req[owner]` falls during LOAD, the load still completes, and RELEASE exits at the next edge with `ack` high for exactly one cycle.
- Reset mid-LOAD or mid-RELEASE: the transaction is aborted and `Q` is cleared to 0, even if the load was in progress.
- Release-into-IDLE boundary: when `req[owner]` falls on the same edge that other requests rise, the RELEASE→IDLE transition takes precedence. The new requests are evaluated in IDLE using the updated `ptr`.
- Single requester held high continuously: it is re-granted every 3 cycles only if it cycles `req` low and high again. A request still high at IDLE is granted again.

## Test plan
- Reset check: drive `clr=0` with `req=4'b1111` → `Q=00`, `Qn=FF`, `gnt=0`, `ack=0`, `busy=0`, `owner=0`. Release `clr` → first grant is `gnt=0001`.
- Single transaction: `req=0010`, `D[1]=8'hA5` → `gnt=0010` after 1 edge; `Q=A5`, `Qn=5A`, `ack=1` after 2 edges. Drop `req` → `gnt=0`, `ack=0`, `busy=0` one edge later.
- Fairness: `req=1111` with `D[i]=8'h10+i`, each requester dropping `req` on `ack` and re-raising it 1 cycle later → grant order 0,1,2,3,0 and `Q` sequence 10,11,12,13,10.
- Pointer skip: `ptr=1` (last winner 1), `req=1001` → `gnt=1000`, `owner=3`, `Q=D[3]`. Next transaction goes to requester 0.
- Early drop: `req[2]` pulsed high for 1 cycle with `D[2]=8'hF0` → `Q=F0` still loaded, `ack` high for exactly 1 cycle, return to IDLE.
- Reset mid-LOAD: assert `clr=0` asynchronously between edges k and k+1 with `Q=3C` before → `Q=00`, `gnt=0` immediately; no load of the pending byte after `clr` is released.
